// File: rtl/reg_bank_rw_if.sv
// Bus between decode/PC logic and the register bank: write port, two read ports, PC port.
// master = decode side, slave = register bank.
interface reg_bank_rw_if #(
    parameter int W = 32,
    parameter int A = 4
);
    logic           we;
    logic [A-1:0]   wa;
    logic [W-1:0]   wd;
    logic [W/8-1:0] wbe;
    logic [A-1:0]   ra1;
    logic [A-1:0]   ra2;
    logic           rd_en;
    logic [W-1:0]   rd1;
    logic [W-1:0]   rd2;
    logic           pc_we;
    logic [W-1:0]   pc_in;
    logic [W-1:0]   pc_out;

    modport master (
        output we, wa, wd, wbe, ra1, ra2, rd_en, pc_we, pc_in,
        input  rd1, rd2, pc_out
    );

    modport slave (
        input  we, wa, wd, wbe, ra1, ra2, rd_en, pc_we, pc_in,
        output rd1, rd2, pc_out
    );
endinterface

// File: rtl/reg_bank_rw.sv
// Multi-entry register bank: byte-lane write port, two read ports, PC in the top entry,
// optional write-to-read bypass and optional held read registers.
module reg_bank_rw #(
    parameter int W       = 32,
    parameter int A       = 4,
    parameter int BYPASS  = 1,
    parameter int REG_OUT = 0
) (
    input  logic          clk,
    input  logic          reset,
    reg_bank_rw_if.slave  bus
);
    localparam int N  = 2 ** A;
    localparam int NB = W / 8;
    localparam logic [A-1:0] PC_ADDR = A'(N - 1);

    logic [W-1:0] mem_q [N];
    logic [W-1:0] wmask;
    logic [W-1:0] wa_base;
    logic [W-1:0] wr_val;
    logic [W-1:0] pc_next;
    logic [W-1:0] f1;
    logic [W-1:0] f2;
    logic         gen_we;
    logic         pc_we_g;
    logic         wa_is_pc;

    // While reset is low nothing is written, so the bypass must not leak pending data either.
    assign gen_we   = bus.we & reset;
    assign pc_we_g  = bus.pc_we & reset;
    assign wa_is_pc = (bus.wa == PC_ADDR);

    always_comb begin
        wmask = '0;
        for (int k = 0; k < NB; k++) begin
            wmask[8*k +: 8] = {8{bus.wbe[k]}};
        end
    end

    // On a PC collision the unenabled lanes come from pc_in rather than the stored PC.
    assign wa_base = (pc_we_g && wa_is_pc) ? bus.pc_in : mem_q[bus.wa];
    assign wr_val  = (bus.wd & wmask) | (wa_base & ~wmask);

    always_comb begin
        pc_next = mem_q[N-1];
        if (gen_we && wa_is_pc) begin
            pc_next = wr_val;
        end else if (pc_we_g) begin
            pc_next = bus.pc_in;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N - 1; i++) begin
                if (gen_we && bus.wa == A'(i)) begin
                    mem_q[i] <= wr_val;
                end
            end
            mem_q[N-1] <= pc_next;
        end
    end

    always_comb begin
        f1 = mem_q[bus.ra1];
        f2 = mem_q[bus.ra2];
        if (BYPASS != 0) begin
            if (bus.ra1 == PC_ADDR) begin
                f1 = pc_next;
            end else if (gen_we && bus.ra1 == bus.wa) begin
                f1 = wr_val;
            end
            if (bus.ra2 == PC_ADDR) begin
                f2 = pc_next;
            end else if (gen_we && bus.ra2 == bus.wa) begin
                f2 = wr_val;
            end
        end
    end

    generate
        if (REG_OUT != 0) begin : g_reg_out
            logic [W-1:0] rd1_q;
            logic [W-1:0] rd2_q;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    rd1_q <= '0;
                    rd2_q <= '0;
                end else if (bus.rd_en) begin
                    rd1_q <= f1;
                    rd2_q <= f2;
                end
            end

            assign bus.rd1 = rd1_q;
            assign bus.rd2 = rd2_q;
        end else begin : g_comb_out
            assign bus.rd1 = f1;
            assign bus.rd2 = f2;
        end
    endgenerate

    assign bus.pc_out = mem_q[N-1];
endmodule

// File: tb/tb_reg_bank_rw.sv
// Bench for reg_bank_rw: three configurations driven in lockstep and checked against an
// entry-array model every cycle, plus directed literal checks.
module tb_reg_bank_rw;
    logic        clk = 1'b0;
    logic        reset;
    logic        we, rd_en, pc_we;
    logic [3:0]  wa, ra1, ra2, wbe;
    logic [31:0] wd, pc_in;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    logic [31:0] mem [16];
    logic [31:0] er1, er2;

    always #5 clk = ~clk;

    reg_bank_rw_if #(.W(32), .A(4)) if_byp ();
    reg_bank_rw_if #(.W(32), .A(4)) if_nob ();
    reg_bank_rw_if #(.W(32), .A(4)) if_reg ();

    assign if_byp.we = we;   assign if_byp.wa = wa;   assign if_byp.wd = wd;   assign if_byp.wbe = wbe;
    assign if_byp.ra1 = ra1; assign if_byp.ra2 = ra2; assign if_byp.rd_en = rd_en;
    assign if_byp.pc_we = pc_we; assign if_byp.pc_in = pc_in;
    assign if_nob.we = we;   assign if_nob.wa = wa;   assign if_nob.wd = wd;   assign if_nob.wbe = wbe;
    assign if_nob.ra1 = ra1; assign if_nob.ra2 = ra2; assign if_nob.rd_en = rd_en;
    assign if_nob.pc_we = pc_we; assign if_nob.pc_in = pc_in;
    assign if_reg.we = we;   assign if_reg.wa = wa;   assign if_reg.wd = wd;   assign if_reg.wbe = wbe;
    assign if_reg.ra1 = ra1; assign if_reg.ra2 = ra2; assign if_reg.rd_en = rd_en;
    assign if_reg.pc_we = pc_we; assign if_reg.pc_in = pc_in;

    reg_bank_rw #(.W(32), .A(4), .BYPASS(1), .REG_OUT(0)) u_byp (.clk(clk), .reset(reset), .bus(if_byp.slave));
    reg_bank_rw #(.W(32), .A(4), .BYPASS(0), .REG_OUT(0)) u_nob (.clk(clk), .reset(reset), .bus(if_nob.slave));
    reg_bank_rw #(.W(32), .A(4), .BYPASS(1), .REG_OUT(1)) u_reg (.clk(clk), .reset(reset), .bus(if_reg.slave));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Value entry x will hold after the coming edge, given the inputs now on the bus.
    function automatic logic [31:0] after_edge(input int x);
        logic [31:0] v;
        v = mem[x];
        if (reset !== 1'b1) return v;
        if (pc_we && x == 15) v = pc_in;
        if (we && int'(wa) == x) begin
            for (int k = 0; k < 4; k++) begin
                if (wbe[k]) v[8*k +: 8] = wd[8*k +: 8];
            end
        end
        return v;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 16; i++) mem[i] = '0;
        er1 = '0;
        er2 = '0;
    endtask

    always @(posedge clk) begin
        logic [31:0] nxt [16];
        if (reset === 1'b1) begin
            for (int i = 0; i < 16; i++) nxt[i] = after_edge(i);
            if (rd_en) begin
                er1 = after_edge(int'(ra1));
                er2 = after_edge(int'(ra2));
            end
            for (int i = 0; i < 16; i++) mem[i] = nxt[i];
        end
    end

    always @(negedge reset) model_clear();

    always @(negedge clk) begin
        if (chk_en) begin
            check("byp_rd1", if_byp.rd1, after_edge(int'(ra1)));
            check("byp_rd2", if_byp.rd2, after_edge(int'(ra2)));
            check("nob_rd1", if_nob.rd1, mem[ra1]);
            check("nob_rd2", if_nob.rd2, mem[ra2]);
            check("reg_rd1", if_reg.rd1, er1);
            check("reg_rd2", if_reg.rd2, er2);
            check("pc_out",  if_byp.pc_out, mem[15]);
            check("pc_out_reg", if_reg.pc_out, mem[15]);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we = 1'b0; pc_we = 1'b0; rd_en = 1'b0; wbe = 4'h0; wd = '0; wa = '0; pc_in = '0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
        we = 1'b1; wa = a; wd = d; wbe = be;
    endtask

    initial begin
        model_clear();
        reset = 1'b0;
        idle();
        ra1 = 4'd3; ra2 = 4'd15;
        wr(4'd3, 32'hDEADBEEF, 4'hF);
        pc_we = 1'b1; pc_in = 32'h0000_0200;
        chk_en = 1'b1;
        repeat (2) step();
        check("rst_rd1", if_byp.rd1, 32'h0);
        check("rst_pc", if_byp.pc_out, 32'h0);
        check("rst_reg_rd1", if_reg.rd1, 32'h0);

        reset = 1'b1;
        step();
        check("rel_rd1", if_nob.rd1, 32'hDEADBEEF);
        check("rel_pc", if_nob.pc_out, 32'h0000_0200);
        idle();

        // byte lanes
        ra1 = 4'd5;
        wr(4'd5, 32'h11223344, 4'hF); step();
        wr(4'd5, 32'hAABBCCDD, 4'b0101); step();
        check("lanes_0101", if_nob.rd1, 32'h11BB33DD);
        wr(4'd5, 32'h99999999, 4'h0); step();
        check("lanes_none", if_nob.rd1, 32'h11BB33DD);
        idle();

        // bypass vs stored read
        ra1 = 4'd2; ra2 = 4'd2;
        wr(4'd2, 32'h55, 4'hF);
        #1;
        check("byp_pre1", if_byp.rd1, 32'h55);
        check("byp_pre2", if_byp.rd2, 32'h55);
        check("nob_pre", if_nob.rd1, 32'h0);
        step();
        idle();
        check("nob_post", if_nob.rd1, 32'h55);

        // PC collision
        pc_we = 1'b1; pc_in = 32'h100; step();
        pc_in = 32'h104;
        wr(4'd15, 32'hFFFF0000, 4'b1100);
        ra1 = 4'd15;
        #1;
        check("pc_byp_pre", if_byp.rd1, 32'hFFFF0104);
        check("pc_nob_pre", if_nob.rd1, 32'h100);
        step();
        check("pc_collide", if_byp.pc_out, 32'hFFFF0104);
        we = 1'b0; step();
        check("pc_alone", if_byp.pc_out, 32'h104);
        idle();

        // registered hold
        ra1 = 4'd7;
        wr(4'd7, 32'hA5, 4'hF); step();
        we = 1'b0; rd_en = 1'b1; step();
        check("reg_load", if_reg.rd1, 32'hA5);
        rd_en = 1'b0;
        wr(4'd7, 32'h5A, 4'hF); step();
        we = 1'b0; step();
        check("reg_hold", if_reg.rd1, 32'hA5);
        check("reg_hold_store", if_nob.rd1, 32'h5A);
        rd_en = 1'b1; step();
        check("reg_reload", if_reg.rd1, 32'h5A);
        idle();

        // short $urandom run against the model
        for (int n = 0; n < 40; n++) begin
            we = 1'($urandom); wa = 4'($urandom); wd = $urandom; wbe = 4'($urandom);
            pc_we = 1'($urandom_range(0, 3) == 0); pc_in = $urandom;
            ra1 = 4'($urandom); ra2 = (n % 5 == 0) ? wa : 4'($urandom);
            rd_en = 1'($urandom);
            step();
        end
        idle();

        // async mid-cycle reset with a held A5
        ra1 = 4'd7;
        wr(4'd7, 32'hA5, 4'hF); rd_en = 1'b1; step();
        idle(); step();
        check("pre_async", if_reg.rd1, 32'hA5);
        #2;
        reset = 1'b0;
        #1;
        check("async_reg_rd1", if_reg.rd1, 32'h0);
        check("async_pc", if_byp.pc_out, 32'h0);
        for (int i = 0; i < 16; i++) begin
            ra2 = 4'(i);
            #0.1;
            check("async_entry", if_nob.rd2, 32'h0);
        end
        step();
        reset = 1'b1;
        repeat (3) step();
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/reg_bank_rw.md
Name: reg_bank_rw

Overview:
- Parametrised register bank for the multi-cycle ARM datapath.
- Generalises the single hold-register into a multi-entry register file with:
  - one write port with byte-lane enables
  - two read ports
  - a dedicated PC entry with its own update port
  - optional write-to-read bypass
  - optional registered read outputs that hold their value
- Sits between decode (addresses) and the ALU operand/PC logic.

Parameters:
- W, 32, data width in bits; must be a multiple of 8.
- A, 4, address width; number of entries N = 2**A; entry N-1 is the PC.
- BYPASS, 1, 1 = a read of the entry being written this cycle returns the merged new value; 0 = returns the stored (old) value.
- REG_OUT, 0, 0 = combinational read data; 1 = read data registered, updated only when rd_en=1, held otherwise.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- we  input  1  general write enable.
- wa  input  A  write address.
- wd  input  W  write data.
- wbe  input  W/8  byte-lane enables; bit k gates wd[8k+7:8k].
- ra1  input  A  read address, port 1.
- ra2  input  A  read address, port 2.
- rd_en  input  1  read-output register enable; ignored when REG_OUT=0.
- rd1  output  W  read data, port 1.
- rd2  output  W  read data, port 2.
- pc_we  input  1  PC update enable.
- pc_in  input  W  next PC value.
- pc_out  output  W  current PC (entry N-1), always combinational from storage.

Behaviour:
- Reset (reset=0, asynchronous, no clock needed):
  - all N entries clear to 0
  - rd1/rd2 output registers (REG_OUT=1) clear to 0
  - pc_out=0
- Reset deassertion takes effect at the next rising edge; no write is performed while reset=0, even if we/pc_we=1.
- General write: on a rising edge with we=1, entry[wa] lane k <= wd lane k for every k with wbe[k]=1; lanes with wbe[k]=0 are unchanged. we=1 with wbe all-zero is a no-op.
- PC write: on a rising edge with pc_we=1, entry[N-1] <= pc_in (full width, wbe ignored).
- Collision: we=1, wa=N-1 and pc_we=1 in the same cycle:
  - the general write wins on lanes with wbe[k]=1
  - pc_in supplies the lanes with wbe[k]=0
  - this matches an explicit write to PC overriding the sequential increment
- Entries other than wa and N-1 are never modified.
- Read, REG_OUT=0: rd1=f(ra1), rd2=f(ra2), combinational, zero-cycle latency.
- f(x) with BYPASS=1:
  - if x equals the entry being written this cycle, f(x) returns the value the entry will hold after the edge
  - this covers both the we/wa path and the pc_we path for x=N-1, including the collision merge
  - otherwise f(x) returns the stored entry
- f(x) with BYPASS=0: always returns the stored entry.
- Read, REG_OUT=1:
  - on a rising edge with rd_en=1: rd1<=f(ra1), rd2<=f(ra2); one-cycle latency
  - rd_en=0: rd1/rd2 hold their last value regardless of writes to the addressed entries
- ra1==ra2 is legal; both ports return identical data.
- pc_out reflects storage only (no bypass); it changes one edge after a PC write.
- Reset asserted mid-operation: state clears immediately; any write in flight on that edge is discarded.

Test Plan:
- Reset: hold reset=0, drive we=1, wa=3, wd=32'hDEADBEEF, wbe=4'hF, pc_we=1 → rd1 (ra1=3)=0, pc_out=0; release reset, one edge → rd1=32'hDEADBEEF, pc_out=pc_in.
- Byte lanes: entry 5 = 32'h11223344; write wd=32'hAABBCCDD, wbe=4'b0101 → entry 5 = 32'h11BB33DD; wbe=0 → unchanged.
- Bypass (BYPASS=1, REG_OUT=0): entry 2 = 32'h0; same cycle we=1, wa=2, wd=32'h55, ra1=2, ra2=2 → rd1=rd2=32'h55 before the edge; with BYPASS=0 → 32'h0 before the edge, 32'h55 after.
- PC collision: pc=32'h100, pc_we=1, pc_in=32'h104, we=1, wa=15, wd=32'hFFFF0000, wbe=4'b1100 → pc_out=32'hFFFF0104 after the edge; pc_we alone → 32'h104.
- Registered hold (REG_OUT=1): ra1=7, rd_en=1, entry 7 = 32'hA5 → rd1=32'hA5 one edge later; rd_en=0, write entry 7 = 32'h5A → rd1 stays 32'hA5; rd_en=1 → rd1=32'h5A next edge.
- Async mid-run reset: assert reset=0 between edges while rd1 (REG_OUT=1) = 32'hA5 → rd1 and all entries read 0 immediately, without waiting for a clock edge.
